// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_pkg
// Description : Shared constants for the PRBS generator/checker: run-time
//               mode encoding, per-polynomial length/tap positions, LFSR
//               seed and the checker lock-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    // Physical LFSR width; shorter polynomials use only the low bits
    localparam int LFSR_W = 31;

    // Every reload (reset or polynomial change) starts from this value
    localparam logic [LFSR_W-1:0] LFSR_SEED = 31'h1;

    // Run-time polynomial selection
    localparam logic [1:0] MODE_PRBS7  = 2'd0;
    localparam logic [1:0] MODE_PRBS15 = 2'd1;
    localparam logic [1:0] MODE_PRBS23 = 2'd2;
    localparam logic [1:0] MODE_PRBS31 = 2'd3;

    // Polynomial x^LEN + x^TAP + 1: output stage is bit LEN-1, tap is TAP-1
    localparam int LEN_PRBS7  = 7;
    localparam int TAP_PRBS7  = 6;
    localparam int LEN_PRBS15 = 15;
    localparam int TAP_PRBS15 = 14;
    localparam int LEN_PRBS23 = 23;
    localparam int TAP_PRBS23 = 18;
    localparam int LEN_PRBS31 = 31;
    localparam int TAP_PRBS31 = 28;

    // Checker lock state
    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : prbs_lfsr
// Description : 31-bit Fibonacci LFSR with run-time polynomial selection.
//               Shifts left one bit per enabled cycle. The shifted-in bit is
//               either the internal feedback (free-running) or an external
//               bit (used by the checker to self-seed from received data).
//               fb is the feedback / predicted next bit, msb the current
//               output stage of the selected polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_lfsr
    import prbs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load_seed,
    input  logic       use_ext,
    input  logic       ext_bit,
    input  logic [1:0] mode,
    output logic       fb,
    output logic       msb
);

    logic [LFSR_W-1:0] lfsr;
    logic              tap_bit;
    logic              shift_in;

    // Select output stage and tap for the active polynomial, form feedback
    always_comb begin
        msb     = lfsr[LEN_PRBS7-1];
        tap_bit = lfsr[TAP_PRBS7-1];
        case (mode)
            MODE_PRBS15: begin
                msb     = lfsr[LEN_PRBS15-1];
                tap_bit = lfsr[TAP_PRBS15-1];
            end
            MODE_PRBS23: begin
                msb     = lfsr[LEN_PRBS23-1];
                tap_bit = lfsr[TAP_PRBS23-1];
            end
            MODE_PRBS31: begin
                msb     = lfsr[LEN_PRBS31-1];
                tap_bit = lfsr[TAP_PRBS31-1];
            end
            default: begin
                msb     = lfsr[LEN_PRBS7-1];
                tap_bit = lfsr[TAP_PRBS7-1];
            end
        endcase
        fb       = msb ^ tap_bit;
        shift_in = use_ext ? ext_bit : fb;
    end

    // Shift register: reload on seed request, otherwise shift when enabled.
    // Bits above the active length keep shifting but are never observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (load_seed) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {lfsr[LFSR_W-2:0], shift_in};
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Module      : prbs_gen_chk
// Description : Run-time selectable PRBS7/15/23/31 serial generator with a
//               self-synchronising checker. The checker seeds itself from
//               received data in SEARCH, declares lock after LOCK_THRESH
//               consecutive correct predictions, then free-runs in LOCKED and
//               counts bit errors in a saturating counter. Too many errors
//               inside one WIN_LEN-bit window drop it back to SEARCH.
//               A one-cycle inject_err pulse corrupts the next emitted bit.
//               Build option PRBS_INVERT_EN adds an 'invert' input that
//               inverts gen_out and the received data before checking.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int ERR_CNT_W   = 16,
    parameter int LOCK_THRESH = 64,
    parameter int WIN_LEN     = 256,
    parameter int LOSS_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 inject_err,
    input  logic                 clr_cnt,
    input  logic                 chk_in,
`ifdef PRBS_INVERT_EN
    input  logic                 invert,
`endif
    output logic                 gen_out,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Counter widths sized so each counter can hold its terminal value
    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int WBIT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    // Terminal values, compared before the increment that would reach them
    localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
    localparam logic [WBIT_W-1:0]    WIN_LAST   = WBIT_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]    LOSS_LAST  = WERR_W'(LOSS_THRESH - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Shared control
    // ------------------------------------------------------------------
    logic [1:0] mode_q;      // polynomial currently in use
    logic       mode_chg;    // request to restart both LFSRs on a new polynomial
    logic       adv;         // advance generator and checker this cycle
    logic       inv;         // optional line inversion

`ifdef PRBS_INVERT_EN
    assign inv = invert;
`else
    assign inv = 1'b0;
`endif

    assign mode_chg = (mode != mode_q);
    // A polynomial change takes the whole cycle; no bit is produced then
    assign adv      = en & ~mode_chg;

    // ------------------------------------------------------------------
    // Generator
    // ------------------------------------------------------------------
    logic gen_msb;
    logic gen_fb;
    logic inj_pend;          // next emitted bit must be flipped

    prbs_lfsr u_gen_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .load_seed (mode_chg),
        .use_ext   (1'b0),
        .ext_bit   (1'b0),
        .mode      (mode_q),
        .fb        (gen_fb),
        .msb       (gen_msb)
    );

    // Registered serial output, pending-injection flag and mode tracking.
    // An inject pulse on an advancing cycle arms the flag for the following
    // bit; repeated pulses while armed do not stack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_PRBS7;
            gen_out  <= 1'b0;
            inj_pend <= 1'b0;
        end else begin
            mode_q <= mode;
            if (adv) begin
                gen_out  <= gen_msb ^ inj_pend ^ inv;
                inj_pend <= inject_err;
            end else if (inject_err) begin
                inj_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    chk_state_t          state;
    logic                chk_fb;
    logic                chk_msb;
    logic                chk_bit;
    logic                mismatch;
    logic                count_err;
    logic [MATCH_W-1:0]  match_cnt;
    logic [WBIT_W-1:0]   win_bit;
    logic [WERR_W-1:0]   win_err;
    logic [ERR_CNT_W-1:0] err_cnt_next;

    assign chk_bit   = chk_in ^ inv;
    // The checker's feedback bit is its prediction of the incoming bit
    assign mismatch  = chk_bit ^ chk_fb;
    assign count_err = adv & (state == ST_LOCKED) & mismatch;
    assign err_cnt_next = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_CNT_W'(1);

    // In SEARCH the checker LFSR loads received bits so that after LEN
    // clean bits its state equals the transmitter's; in LOCKED it runs on
    // its own prediction so line errors are not propagated into the state.
    prbs_lfsr u_chk_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .load_seed (mode_chg),
        .use_ext   (state == ST_SEARCH),
        .ext_bit   (chk_bit),
        .mode      (mode_q),
        .fb        (chk_fb),
        .msb       (chk_msb)
    );

    // Generator feedback and checker output stage are not needed here
    logic unused_lfsr_taps;
    assign unused_lfsr_taps = gen_fb ^ chk_msb;

    // Lock state machine, loss-of-lock window supervision and error counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SEARCH;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            match_cnt <= '0;
            win_bit   <= '0;
            win_err   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (mode_chg) begin
                state     <= ST_SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
                win_bit   <= '0;
                win_err   <= '0;
            end else if (en) begin
                if (state == ST_SEARCH) begin
                    if (mismatch) begin
                        match_cnt <= '0;
                    end else if (match_cnt == MATCH_LAST) begin
                        state     <= ST_LOCKED;
                        locked    <= 1'b1;
                        match_cnt <= '0;
                        win_bit   <= '0;
                        win_err   <= '0;
                    end else begin
                        match_cnt <= match_cnt + MATCH_W'(1);
                    end
                end else begin
                    err_pulse <= mismatch;
                    if (mismatch && (win_err == LOSS_LAST)) begin
                        state     <= ST_SEARCH;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        win_bit   <= '0;
                        win_err   <= '0;
                    end else if (win_bit == WIN_LAST) begin
                        // Window closes: start a fresh error budget
                        win_bit <= '0;
                        win_err <= '0;
                    end else begin
                        win_bit <= win_bit + WBIT_W'(1);
                        if (mismatch) begin
                            win_err <= win_err + WERR_W'(1);
                        end
                    end
                end
            end

            // Clear takes priority over a coincident error
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (count_err) begin
                err_cnt <= err_cnt_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Testbench : tb_prbs_gen_chk
// Two DUTs share stimulus: u_dut0 with default parameters, u_dut1 with a
// 4-bit error counter and an unreachable loss threshold. A bit-stream model
// (recurrence over past bits) predicts every output on every cycle.
// ============================================================================
`timescale 1ns/1ps
module tb_prbs_gen_chk;

    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       inject_err = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       chk_rand = 1'b1;
    logic       rnd_bit = 1'b0;
    logic       en_rand = 1'b0;

    logic       gen_out0, locked0, err_pulse0, chk0;
    logic       gen_out1, locked1, err_pulse1, chk1;
    logic [15:0] err_cnt0;
    logic [3:0]  err_cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    always #5 clk = ~clk;

    assign chk0 = chk_rand ? rnd_bit : gen_out0;
    assign chk1 = chk_rand ? rnd_bit : gen_out1;

    prbs_gen_chk u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .clr_cnt(clr_cnt), .chk_in(chk0), .gen_out(gen_out0), .locked(locked0),
        .err_pulse(err_pulse0), .err_cnt(err_cnt0)
    );

    prbs_gen_chk #(.ERR_CNT_W(4), .LOCK_THRESH(64), .WIN_LEN(256), .LOSS_THRESH(300)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
        .clr_cnt(clr_cnt), .chk_in(chk1), .gen_out(gen_out1), .locked(locked1),
        .err_pulse(err_pulse1), .err_cnt(err_cnt1)
    );

    logic        d_gen[NI];
    logic        d_lock[NI];
    logic        d_pulse[NI];
    logic [15:0] d_err[NI];
    assign d_gen[0] = gen_out0;   assign d_gen[1] = gen_out1;
    assign d_lock[0] = locked0;   assign d_lock[1] = locked1;
    assign d_pulse[0] = err_pulse0; assign d_pulse[1] = err_pulse1;
    assign d_err[0] = err_cnt0;   assign d_err[1] = {12'd0, err_cnt1};

    // ---------------- behavioural model ----------------
    function automatic int plen(logic [1:0] m);
        case (m) 2'd0: return 7; 2'd1: return 15; 2'd2: return 23; default: return 31; endcase
    endfunction
    function automatic int ptap(logic [1:0] m);
        case (m) 2'd0: return 6; 2'd1: return 14; 2'd2: return 18; default: return 28; endcase
    endfunction
    function automatic int loss_th(int i); return (i == 0) ? 8 : 300; endfunction
    function automatic int err_max(int i); return (i == 0) ? 65535 : 15; endfunction

    // Stream histories, newest bit at the back; seed history is 30 zeros then a one
    bit         ghist[NI][$];
    bit         chist[NI][$];
    logic [1:0] m_mode[NI];
    bit         m_gen[NI], m_flag[NI], m_lock[NI], m_pulse[NI];
    int         m_match[NI], m_wbit[NI], m_werr[NI], m_err[NI];

    function automatic void seed_hist(int i);
        ghist[i].delete(); chist[i].delete();
        for (int k = 0; k < 30; k++) begin ghist[i].push_back(1'b0); chist[i].push_back(1'b0); end
        ghist[i].push_back(1'b1); chist[i].push_back(1'b1);
    endfunction

    function automatic void restart_chk(int i);
        m_lock[i] = 1'b0; m_match[i] = 0; m_wbit[i] = 0; m_werr[i] = 0;
    endfunction

    function automatic void model_reset(int i);
        seed_hist(i); restart_chk(i);
        m_mode[i] = 2'd0; m_gen[i] = 1'b0; m_flag[i] = 1'b0; m_pulse[i] = 1'b0; m_err[i] = 0;
    endfunction

    function automatic void model_step(int i);
        int n, t, gs, cs;
        bit rx, out_bit, pred, mis;
        rx = chk_rand ? rnd_bit : m_gen[i];
        m_pulse[i] = 1'b0;
        if (mode != m_mode[i]) begin
            m_mode[i] = mode; seed_hist(i); restart_chk(i);
            if (inject_err) m_flag[i] = 1'b1;
        end else if (en) begin
            n = plen(m_mode[i]); t = ptap(m_mode[i]);
            gs = ghist[i].size(); cs = chist[i].size();
            // Emitted bit is the stream bit N back; new stream bit = s[-N] ^ s[-T]
            out_bit = ghist[i][gs-n];
            ghist[i].push_back(out_bit ^ ghist[i][gs-t]);
            void'(ghist[i].pop_front());
            m_gen[i]  = out_bit ^ m_flag[i];
            m_flag[i] = inject_err;
            pred = chist[i][cs-n] ^ chist[i][cs-t];
            mis  = rx ^ pred;
            if (!m_lock[i]) begin
                chist[i].push_back(rx);
                m_match[i] = mis ? 0 : m_match[i] + 1;
                if (m_match[i] == 64) begin restart_chk(i); m_lock[i] = 1'b1; end
            end else begin
                chist[i].push_back(pred);
                if (mis) begin
                    m_pulse[i] = 1'b1;
                    if (m_err[i] < err_max(i)) m_err[i]++;
                    m_werr[i]++;
                end
                if (m_werr[i] == loss_th(i)) restart_chk(i);
                else begin
                    m_wbit[i]++;
                    if (m_wbit[i] == 256) begin m_wbit[i] = 0; m_werr[i] = 0; end
                end
            end
            void'(chist[i].pop_front());
        end else if (inject_err) begin
            m_flag[i] = 1'b1;
        end
        if (clr_cnt) m_err[i] = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) model_reset(i);
            else        model_step(i);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                n_tests++;
                if (d_gen[i] !== m_gen[i] || d_lock[i] !== m_lock[i] ||
                    d_pulse[i] !== m_pulse[i] || int'(d_err[i]) != m_err[i]) begin
                    n_fail++;
                    if (n_print < 40) begin
                        n_print++;
                        $display("FAIL cycle dut%0d @%0t: gen %0b exp %0b, locked %0b exp %0b, err_pulse %0b exp %0b, err_cnt %0d exp %0d",
                                 i, $time, d_gen[i], m_gen[i], d_lock[i], m_lock[i],
                                 d_pulse[i], m_pulse[i], d_err[i], m_err[i]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        rnd_bit    = 1'($urandom_range(0, 1));
        en         = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        inject_err = 1'b0;
        clr_cnt    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gen0"}, int'(gen_out0), 0);
        check({tag, "_locked0"}, int'(locked0), 0);
        check({tag, "_pulse0"}, int'(err_pulse0), 0);
        check({tag, "_cnt0"}, int'(err_cnt0), 0);
        check({tag, "_gen1"}, int'(gen_out1), 0);
        check({tag, "_cnt1"}, int'(err_cnt1), 0);
    endtask

    bit seq[300];

    initial begin
        int ones, per_err, pulses, saved;
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // PRBS7 free run with random line input; pin the model's stream
        for (int k = 0; k < 300; k++) begin step(); seq[k] = m_gen[0]; end
        check("prbs7_first7", int'({seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6]}), 1);
        ones = 0; per_err = 0;
        for (int k = 0; k < 127; k++) ones += int'(seq[k]);
        for (int k = 0; k < 150; k++) if (seq[k] != seq[k+127]) per_err++;
        check("prbs7_ones_per_period", ones, 64);
        check("prbs7_period127", per_err, 0);
        check("prbs7_nolock", int'(locked0), 0);
        check("prbs7_cnt", int'(err_cnt0), 0);

        // PRBS31 loopback: lock needs at least 64 bits
        chk_rand = 1'b0; mode = 2'd3;
        step();                              // polynomial-change cycle
        for (int k = 0; k < 63; k++) step();
        check("prbs31_not_yet_locked", int'(locked0), 0);
        for (int k = 0; k < 137; k++) step();
        check("prbs31_locked", int'(locked0), 1);
        for (int k = 0; k < 9800; k++) step();
        check("prbs31_clean_cnt", int'(err_cnt0), 0);
        check("prbs31_still_locked", int'(locked0), 1);

        // Single injected error
        inject_err = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin step(); pulses += int'(err_pulse0); end
        check("inject_pulses", pulses, 1);
        check("inject_cnt", int'(err_cnt0), 1);
        check("inject_locked", int'(locked0), 1);

        // Garbage on the line: dut0 loses lock, dut1 counter saturates
        chk_rand = 1'b1; en_rand = 1'b1;
        for (int k = 0; k < 400; k++) step();
        check("garbage_lost_lock", int'(locked0), 0);
        check("garbage_sat_cnt1", int'(err_cnt1), 15);
        check("garbage_dut1_locked", int'(locked1), 1);

        // Reconnect: relock
        chk_rand = 1'b0; en_rand = 1'b0;
        for (int k = 0; k < 200; k++) step();
        check("relock", int'(locked0), 1);

        // Polynomial change 3 -> 1 while locked
        saved = m_err[0];
        mode = 2'd1;
        step();
        check("modechg_unlock", int'(locked0), 0);
        check("modechg_cnt_kept", int'(err_cnt0), saved);
        for (int k = 0; k < 200; k++) step();
        check("prbs15_relock", int'(locked0), 1);

        // Clear coincident with a detected error
        inject_err = 1'b1;
        step();
        step(); clr_cnt = 1'b1;
        step();
        check("clr_vs_err_pulse", int'(err_pulse0), 1);
        check("clr_vs_err_cnt", int'(err_cnt0), 0);

        // Random mix of everything
        en_rand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step();
            if ($urandom_range(0, 49) == 0)  inject_err = 1'b1;
            if ($urandom_range(0, 199) == 0) clr_cnt = 1'b1;
            if ($urandom_range(0, 299) == 0) chk_rand = ~chk_rand;
            if ($urandom_range(0, 499) == 0) mode = 2'($urandom_range(0, 3));
        end

        // Asynchronous reset mid-run
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        check("async_reset_locked1", int'(locked1), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        en_rand = 1'b0; chk_rand = 1'b0; mode = 2'd0;
        for (int k = 0; k < 200; k++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
